// File: rtl/serial_sub_pkg.sv
// Shared definitions for the digit-serial 32-bit subtractor: state encoding,
// datapath width and the set of supported digit sizes.
package serial_sub_pkg;

  localparam int WIDTH     = 32;
  localparam int NUM_LEGAL = 4;
  localparam int LEGAL_DIGITS [NUM_LEGAL] = '{1, 2, 4, 8};

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DONE
  } state_t;

  function automatic bit digit_is_legal(input int d);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < NUM_LEGAL; i++) begin
      if (LEGAL_DIGITS[i] == d) ok = 1'b1;
    end
    return ok;
  endfunction

endpackage

// File: rtl/sub_slice.sv
// DIGIT-bit ripple-carry adder slice; the caller feeds the inverted
// subtrahend so the slice itself is a plain adder.
module sub_slice #(
  parameter int DIGIT = 1
) (
  input  logic [DIGIT-1:0] a_dig,
  input  logic [DIGIT-1:0] b_dig,
  input  logic             cin,
  output logic [DIGIT-1:0] sum_dig,
  output logic             cout
);

  logic [DIGIT:0]   c;
  logic [DIGIT-1:0] p;
  logic [DIGIT-1:0] g;
  logic [DIGIT-1:0] t;

  assign c[0] = cin;

  for (genvar i = 0; i < DIGIT; i++) begin : g_bit
    xor u_p   (p[i],       a_dig[i], b_dig[i]);
    xor u_s   (sum_dig[i], p[i],     c[i]);
    and u_g   (g[i],       a_dig[i], b_dig[i]);
    and u_t   (t[i],       p[i],     c[i]);
    or  u_c   (c[i+1],     g[i],     t[i]);
  end

  assign cout = c[DIGIT];

endmodule

// File: rtl/serial_sub_32.sv
// Digit-serial 32-bit subtractor: computes a + ~b + 1 DIGIT bits per cycle
// with a valid/ready handshake on both the operand and result sides.
module serial_sub_32
  import serial_sub_pkg::*;
#(
  parameter int DIGIT = 1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] diff,
  output logic        borrow,
  output logic        ovf,
  output logic        zero
);

  localparam int N     = WIDTH / DIGIT;
  localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

  if (!digit_is_legal(DIGIT)) begin : g_bad_digit
    $error("serial_sub_32: DIGIT must be 1, 2, 4 or 8");
  end

  state_t           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] diff_sh_q, diff_sh_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic             a_msb_q, a_msb_d;
  logic             b_msb_q, b_msb_d;
  logic             borrow_q, borrow_d;
  logic             ovf_q, ovf_d;
  logic             zero_q, zero_d;

  logic [DIGIT-1:0] slice_sum;
  logic             slice_cout;

  sub_slice #(.DIGIT(DIGIT)) u_slice (
    .a_dig   (a_sh_q[DIGIT-1:0]),
    .b_dig   (b_sh_q[DIGIT-1:0]),
    .cin     (carry_q),
    .sum_dig (slice_sum),
    .cout    (slice_cout)
  );

  always_comb begin
    state_d   = state_q;
    a_sh_d    = a_sh_q;
    b_sh_d    = b_sh_q;
    diff_sh_d = diff_sh_q;
    cnt_d     = cnt_q;
    carry_d   = carry_q;
    a_msb_d   = a_msb_q;
    b_msb_d   = b_msb_q;
    borrow_d  = borrow_q;
    ovf_d     = ovf_q;
    zero_d    = zero_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          a_sh_d    = a;
          b_sh_d    = ~b;
          carry_d   = 1'b1;
          a_msb_d   = a[WIDTH-1];
          b_msb_d   = b[WIDTH-1];
          cnt_d     = '0;
          diff_sh_d = '0;
          state_d   = ST_RUN;
        end
      end
      ST_RUN: begin
        a_sh_d    = a_sh_q >> DIGIT;
        b_sh_d    = b_sh_q >> DIGIT;
        carry_d   = slice_cout;
        cnt_d     = cnt_q + CNT_W'(1);
        diff_sh_d = {slice_sum, diff_sh_q[WIDTH-1:DIGIT]};
        if (cnt_q == LAST) begin
          // Flags are derived from the fully assembled difference on this edge.
          borrow_d = ~slice_cout;
          ovf_d    = (a_msb_q != b_msb_q) & (diff_sh_d[WIDTH-1] != a_msb_q);
          zero_d   = (diff_sh_d == '0);
          state_d  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          borrow_d = 1'b0;
          ovf_d    = 1'b0;
          zero_d   = 1'b0;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= ST_IDLE;
      a_sh_q    <= '0;
      b_sh_q    <= '0;
      diff_sh_q <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      a_msb_q   <= 1'b0;
      b_msb_q   <= 1'b0;
      borrow_q  <= 1'b0;
      ovf_q     <= 1'b0;
      zero_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      a_sh_q    <= a_sh_d;
      b_sh_q    <= b_sh_d;
      diff_sh_q <= diff_sh_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      a_msb_q   <= a_msb_d;
      b_msb_q   <= b_msb_d;
      borrow_q  <= borrow_d;
      ovf_q     <= ovf_d;
      zero_q    <= zero_d;
    end
  end

  // Results are masked outside DONE so partial sums never leak out.
  assign in_ready  = (state_q == ST_IDLE);
  assign out_valid = (state_q == ST_DONE);
  assign diff      = out_valid ? diff_sh_q : '0;
  assign borrow    = out_valid & borrow_q;
  assign ovf       = out_valid & ovf_q;
  assign zero      = out_valid & zero_q;

endmodule

// File: tb/tb_serial_sub_32.sv
// Scoreboard bench for serial_sub_32: one instance with DIGIT=1, one with DIGIT=8.
module tb_serial_sub_32;

  typedef struct {
    logic [31:0] d;
    logic        bo;
    logic        ov;
    logic        ze;
    int          acc;
  } exp_t;

  logic        clk;
  logic        rst_n;
  logic [1:0]  in_valid;
  logic [1:0]  in_ready;
  logic [1:0]  out_valid;
  logic [1:0]  out_ready;
  logic [1:0]  borrow;
  logic [1:0]  ovf;
  logic [1:0]  zero;
  logic [31:0] a_i    [2];
  logic [31:0] b_i    [2];
  logic [31:0] diff_o [2];

  exp_t q [2][$];
  bit   seen [2];
  int   cyc;
  int   checks;
  int   failures;
  int   lat_exp [2];

  serial_sub_32 #(.DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[0]), .in_ready(in_ready[0]),
    .a(a_i[0]), .b(b_i[0]), .out_valid(out_valid[0]), .out_ready(out_ready[0]),
    .diff(diff_o[0]), .borrow(borrow[0]), .ovf(ovf[0]), .zero(zero[0])
  );

  serial_sub_32 #(.DIGIT(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid[1]), .in_ready(in_ready[1]),
    .a(a_i[1]), .b(b_i[1]), .out_valid(out_valid[1]), .out_ready(out_ready[1]),
    .diff(diff_o[1]), .borrow(borrow[1]), .ovf(ovf[1]), .zero(zero[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [39:0] act, input logic [39:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Monitor: compares the presented result with the queue head every cycle it is valid.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int i = 0; i < 2; i++) begin
        if (out_valid[i]) begin
          if (q[i].size() == 0) begin
            chk($sformatf("unexpected_result_%0d", i), 40'(out_valid[i]), 40'd0);
          end else begin
            if (!seen[i]) begin
              seen[i] = 1'b1;
              chk($sformatf("latency_%0d", i), 40'(cyc - q[i][0].acc), 40'(lat_exp[i]));
            end
            chk($sformatf("diff_%0d", i),   40'(diff_o[i]), 40'(q[i][0].d));
            chk($sformatf("borrow_%0d", i), 40'(borrow[i]), 40'(q[i][0].bo));
            chk($sformatf("ovf_%0d", i),    40'(ovf[i]),    40'(q[i][0].ov));
            chk($sformatf("zero_%0d", i),   40'(zero[i]),   40'(q[i][0].ze));
            if (out_ready[i]) begin
              void'(q[i].pop_front());
              seen[i] = 1'b0;
            end
          end
        end else begin
          chk($sformatf("idle_outputs_zero_%0d", i),
              40'({diff_o[i], borrow[i], ovf[i], zero[i]}), 40'd0);
        end
      end
    end
  end

  // Called at posedge+1; returns at posedge+2 after the accept edge.
  task automatic send(input int i, input logic [31:0] av, input logic [31:0] bv,
                      input logic [31:0] ed, input logic eb, input logic eo, input logic ez);
    int   k;
    exp_t e;
    k = 0;
    while (!in_ready[i] && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    chk($sformatf("accept_wait_%0d", i), 40'(in_ready[i]), 40'd1);
    a_i[i]      = av;
    b_i[i]      = bv;
    in_valid[i] = 1'b1;
    @(posedge clk); #1;
    e.d   = ed;
    e.bo  = eb;
    e.ov  = eo;
    e.ze  = ez;
    e.acc = cyc;
    q[i].push_back(e);
    in_valid[i] = 1'b0;
    a_i[i]      = $urandom;
    b_i[i]      = $urandom;
    #1;
  endtask

  task automatic drain(input int i);
    int k;
    k = 0;
    while (q[i].size() != 0 && k < 500) begin
      @(posedge clk);
      k++;
    end
    #1;
    chk($sformatf("drain_%0d", i), 40'(q[i].size()), 40'd0);
  endtask

  initial begin
    int k;
    checks     = 0;
    failures   = 0;
    lat_exp[0] = 32;
    lat_exp[1] = 4;
    seen[0]    = 1'b0;
    seen[1]    = 1'b0;
    rst_n      = 1'b0;
    in_valid   = 2'b00;
    out_ready  = 2'b11;
    for (int i = 0; i < 2; i++) begin
      a_i[i] = 32'hDEADBEEF;
      b_i[i] = 32'hCAFEF00D;
    end

    repeat (3) @(posedge clk);
    #1;
    for (int i = 0; i < 2; i++) begin
      chk($sformatf("rst_in_ready_%0d", i),  40'(in_ready[i]),  40'd1);
      chk($sformatf("rst_out_valid_%0d", i), 40'(out_valid[i]), 40'd0);
      chk($sformatf("rst_outputs_%0d", i),
          40'({diff_o[i], borrow[i], ovf[i], zero[i]}), 40'd0);
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("first_cycle_in_ready", 40'(in_ready[0]), 40'd1);

    send(0, 32'd5,          32'd3,          32'h00000002, 1'b0, 1'b0, 1'b0);
    send(1, 32'h12345678,   32'h12345678,   32'h00000000, 1'b0, 1'b0, 1'b1);
    send(1, 32'hFFFFFFFF,   32'h00000001,   32'hFFFFFFFE, 1'b0, 1'b0, 1'b0);
    send(0, 32'd3,          32'd5,          32'hFFFFFFFE, 1'b1, 1'b0, 1'b0);
    send(1, 32'h00000001,   32'h00000002,   32'hFFFFFFFF, 1'b1, 1'b0, 1'b0);
    send(1, 32'h80000000,   32'h7FFFFFFF,   32'h00000001, 1'b0, 1'b1, 1'b0);
    send(0, 32'h80000000,   32'h00000001,   32'h7FFFFFFF, 1'b0, 1'b1, 1'b0);
    send(0, 32'h00000000,   32'h00000000,   32'h00000000, 1'b0, 1'b0, 1'b1);
    send(0, 32'h7FFFFFFF,   32'hFFFFFFFF,   32'h80000000, 1'b1, 1'b1, 1'b0);
    drain(0);
    drain(1);
    @(posedge clk); #1;

    // Back-pressure: result held 10 cycles while in_valid and operands churn.
    out_ready[0] = 1'b0;
    send(0, 32'd9, 32'd4, 32'd5, 1'b0, 1'b0, 1'b0);
    k = 0;
    while (!out_valid[0] && k < 100) begin
      in_valid[0] = 1'b1;
      a_i[0]      = $urandom;
      b_i[0]      = $urandom;
      @(posedge clk); #1;
      chk("run_in_ready", 40'(in_ready[0]), 40'd0);
      k++;
    end
    chk("done_reached", 40'(out_valid[0]), 40'd1);
    repeat (10) begin
      in_valid[0] = 1'b1;
      a_i[0]      = $urandom;
      b_i[0]      = $urandom;
      @(posedge clk); #1;
      chk("done_in_ready", 40'(in_ready[0]),  40'd0);
      chk("done_hold",     40'(out_valid[0]), 40'd1);
    end
    in_valid[0]  = 1'b0;
    out_ready[0] = 1'b1;
    @(posedge clk); #1;
    chk("ack_in_ready",  40'(in_ready[0]),  40'd1);
    chk("ack_out_valid", 40'(out_valid[0]), 40'd0);
    chk("ack_queue",     40'(q[0].size()),  40'd0);

    // Reset in the middle of a computation aborts it.
    send(0, 32'h11111111, 32'h00000001, 32'h11111110, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #3;
    rst_n = 1'b0;
    q[0].delete();
    seen[0] = 1'b0;
    #1;
    chk("abort_in_ready",  40'(in_ready[0]),  40'd1);
    chk("abort_out_valid", 40'(out_valid[0]), 40'd0);
    chk("abort_outputs",   40'({diff_o[0], borrow[0], ovf[0], zero[0]}), 40'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("post_reset_in_ready", 40'(in_ready[0]), 40'd1);
    send(0, 32'd7, 32'd2, 32'd5, 1'b0, 1'b0, 1'b0);
    drain(0);
    drain(1);
    repeat (3) @(posedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
